// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg: shared constants for the 16x8 single-port RAM bus initiator.
//  - AW_DEF/DW_DEF : default address/data widths
//  - ST_*          : FSM state encodings (IDLE, WR, RD_ADDR, RD_DATA, TURN, RSP)
//  - OP_RD/OP_WR   : request opcode values carried on req_write_i
package ram_bus_pkg;

    localparam int unsigned AW_DEF = 4;
    localparam int unsigned DW_DEF = 8;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_WR      = 3'd1;
    localparam logic [ST_W-1:0] ST_RD_ADDR = 3'd2;
    localparam logic [ST_W-1:0] ST_RD_DATA = 3'd3;
    localparam logic [ST_W-1:0] ST_TURN    = 3'd4;
    localparam logic [ST_W-1:0] ST_RSP     = 3'd5;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/ram_data_pad.sv
// ram_data_pad: DW-wide tristate buffer isolating the shared RAM data bus.
//  oe_i    : drive enable (bus driven with dout_i when 1, released to Z otherwise)
//  dout_i  : value driven onto the bus
//  din_o   : value currently observed on the bus
//  pad_io  : shared bidirectional data bus
module ram_data_pad #(
    parameter int unsigned DW = 8
) (
    input  logic          oe_i,
    input  logic [DW-1:0] dout_i,
    output logic [DW-1:0] din_o,
    inout  wire  [DW-1:0] pad_io
);

    assign pad_io = oe_i ? dout_i : {DW{1'bz}};
    assign din_o  = pad_io;

endmodule

// File: rtl/ram_bus_master.sv
// ram_bus_master: converts valid/ready read/write requests into RAM bus cycles
// on a single-port RAM with separate write/read addresses and a shared data bus.
//  clk, rst                    : clock, synchronous active-high reset
//  req_valid_i/req_ready_o     : request handshake
//  req_write_i/req_addr_i/
//  req_wdata_i                 : request opcode, address, write data
//  rsp_valid_o/rsp_ready_i     : response handshake (held until consumed)
//  rsp_rdata_o/rsp_err_o       : read data, write-verify mismatch flag
//  ram_wr_addr_o/ram_rd_addr_o : RAM addresses
//  ram_we_o/ram_re_o           : RAM strobes (never both high)
//  ram_data_io                 : shared data bus, driven only during write cycles
// Optional feature: define WRITE_VERIFY_EN to read back every write and report
// a mismatch on rsp_err_o; otherwise writes complete without a response.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_write_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] ram_wr_addr_o,
    output logic [AW-1:0] ram_rd_addr_o,
    output logic          ram_we_o,
    output logic          ram_re_o,
    inout  wire  [DW-1:0] ram_data_io
);

`ifdef WRITE_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    logic [ST_W-1:0] state_q, state_d;
    logic            op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [AW-1:0]   ram_wr_addr_q, ram_wr_addr_d;
    logic [AW-1:0]   ram_rd_addr_q, ram_rd_addr_d;
    logic            ram_we_q, ram_we_d;
    logic            ram_re_q, ram_re_d;
    logic            data_oe_q, data_oe_d;
    logic [DW-1:0]   din;

    // Bus pad: drives the latched write data only during the write cycle
    ram_data_pad #(.DW(DW)) u_pad (
        .oe_i   (data_oe_q),
        .dout_i (wdata_q),
        .din_o  (din),
        .pad_io (ram_data_io)
    );

    // Next state plus registered outputs decoded from the next state, so every
    // bus strobe lines up with the cycle its state occupies
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_rd_addr_d = ram_rd_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    op_d    = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = req_write_i ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR:      state_d = VERIFY_EN ? ST_RD_ADDR : ST_IDLE;
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                // RAM drives the bus this cycle; capture at the closing edge
                rsp_rdata_d = din;
                rsp_err_d   = VERIFY_EN && (op_q == OP_WR) && (din != wdata_q);
                state_d     = ST_TURN;
            end
            ST_TURN:    state_d = ST_RSP;
            ST_RSP: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RSP);
        ram_we_d    = (state_d == ST_WR);
        ram_re_d    = (state_d == ST_RD_ADDR) || (state_d == ST_RD_DATA);
        data_oe_d   = (state_d == ST_WR);

        if (state_d == ST_WR) begin
            ram_wr_addr_d = addr_d;
        end
        if (state_d == ST_RD_ADDR) begin
            ram_wr_addr_d = addr_d;
            ram_rd_addr_d = addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_RD;
            addr_q        <= '0;
            wdata_q       <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_rd_addr_q <= '0;
            ram_we_q      <= 1'b0;
            ram_re_q      <= 1'b0;
            data_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_rd_addr_q <= ram_rd_addr_d;
            ram_we_q      <= ram_we_d;
            ram_re_q      <= ram_re_d;
            data_oe_q     <= data_oe_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign ram_wr_addr_o = ram_wr_addr_q;
    assign ram_rd_addr_o = ram_rd_addr_q;
    assign ram_we_o      = ram_we_q;
    assign ram_re_o      = ram_re_q;

endmodule
